// File: rtl/perf_uart_reporter.sv
// perf_uart_reporter: snapshots core performance counters and sends them as a 14-byte UART 8N1 frame
//   clk, rst_n                          : core clock, asynchronous active-low reset
//   start                               : level request, sampled only while idle
//   clk_cycles .. invalid_clk_cycles    : counters captured into the snapshot on start acceptance
//   tx                                  : UART line, idle high, LSB first
//   busy                                : high from start acceptance until the last stop bit ends
//   done                                : one-cycle pulse after the final stop bit
module perf_uart_reporter #(
    parameter int         CLKS_PER_BIT = 651,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [27:0] clk_cycles,
    input  logic [12:0] retired_instructions,
    input  logic [12:0] predictions_made,
    input  logic [12:0] correct_predictions,
    input  logic [12:0] invalid_clk_cycles,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP, FIN} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       idx_q, idx_d;
    logic [7:0]       chk_q, chk_d, shift_q, shift_d;
    logic [79:0]      snap_q, snap_d;
    logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic             bit_end;
    logic [95:0]      payload;
    logic [7:0]       cur_byte;
    // Bytes 1..12 of the frame, little endian, fields zero-extended
    assign payload  = {3'b0, snap_q[79:67], 3'b0, snap_q[66:54], 3'b0, snap_q[53:41],
                       3'b0, snap_q[40:28], 4'b0, snap_q[27:0]};
    assign cur_byte = idx_q == 4'd0  ? SYNC_BYTE :
                      idx_q == 4'd13 ? chk_q :
                      8'(payload >> {idx_q - 4'd1, 3'b000});
    assign bit_end  = baud_q == CNT_W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            chk_q   <= '0;
            shift_q <= '0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            chk_q   <= chk_d;
            shift_q <= shift_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        idx_d   = idx_q;
        chk_d   = chk_q;
        shift_d = shift_q;
        snap_d  = snap_q;
        if (state_q == START_BIT || state_q == DATA || state_q == STOP)
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        case (state_q)
            IDLE: if (start) begin
                state_d = START_BIT;
                idx_d   = '0;
                chk_d   = '0;
                snap_d  = {invalid_clk_cycles, correct_predictions, predictions_made,
                           retired_instructions, clk_cycles};
            end
            // Bytes are fetched at the end of their start bit; the checksum folds in B1..B12 only
            START_BIT: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
                shift_d = cur_byte;
                chk_d   = (idx_q != 4'd0 && idx_q != 4'd13) ? chk_q ^ cur_byte : chk_q;
            end
            DATA: if (bit_end) begin
                state_d = bit_q == 3'd7 ? STOP : DATA;
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
            end
            STOP: if (bit_end) begin
                state_d = idx_q == 4'd13 ? FIN : START_BIT;
                idx_d   = idx_q + 4'd1;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // Outputs are registered from the next state so the line never glitches
    always_comb begin
        tx_d   = state_d == START_BIT ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
        busy_d = state_d == START_BIT || state_d == DATA || state_d == STOP;
        done_d = state_d == FIN;
    end
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_perf_uart_reporter.sv
// tb_perf_uart_reporter: randomized frame checks of perf_uart_reporter against a byte-level frame model
module tb_perf_uart_reporter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [27:0] clk_cycles;
    logic [12:0] retired_instructions, predictions_made, correct_predictions, invalid_clk_cycles;
    logic        tx1, busy1, done1, tx2, busy2, done2;
    logic        tx_s, busy_s, done_s;
    bit          sel = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q [14];
    logic [7:0]  rx_q [14];
    logic [7:0]  golden_b [14] = '{8'hA5, 8'hEF, 8'hCD, 8'hAB, 8'h00, 8'h34, 8'h12,
                                   8'h00, 8'h01, 8'hF0, 8'h00, 8'h05, 8'h00, 8'h5B};

    always #5 clk = ~clk;

    perf_uart_reporter #(.CLKS_PER_BIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clk_cycles(clk_cycles),
        .retired_instructions(retired_instructions), .predictions_made(predictions_made),
        .correct_predictions(correct_predictions), .invalid_clk_cycles(invalid_clk_cycles),
        .tx(tx1), .busy(busy1), .done(done1));

    perf_uart_reporter #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .clk_cycles(clk_cycles),
        .retired_instructions(retired_instructions), .predictions_made(predictions_made),
        .correct_predictions(correct_predictions), .invalid_clk_cycles(invalid_clk_cycles),
        .tx(tx2), .busy(busy2), .done(done2));

    assign tx_s   = sel ? tx2 : tx1;
    assign busy_s = sel ? busy2 : busy1;
    assign done_s = sel ? done2 : done1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame model: sync, 32-bit LE clk_cycles, four 16-bit LE fields, XOR of B1..B12
    function automatic void build_frame();
        int unsigned f [4];
        f = '{32'(retired_instructions), 32'(predictions_made),
              32'(correct_predictions), 32'(invalid_clk_cycles)};
        exp_q[0] = 8'hA5;
        for (int i = 0; i < 4; i++) exp_q[1 + i] = 8'((32'(clk_cycles) >> (8 * i)) & 32'hFF);
        for (int j = 0; j < 4; j++) begin
            exp_q[5 + 2 * j] = 8'(f[j] & 32'hFF);
            exp_q[6 + 2 * j] = 8'((f[j] >> 8) & 32'hFF);
        end
        exp_q[13] = 8'h00;
        for (int i = 1; i <= 12; i++) exp_q[13] = exp_q[13] ^ exp_q[i];
    endfunction

    task automatic set_golden();
        clk_cycles = 28'h0ABCDEF;
        retired_instructions = 13'h1234;
        predictions_made = 13'h0100;
        correct_predictions = 13'h00F0;
        invalid_clk_cycles = 13'h0005;
    endtask

    task automatic set_random();
        clk_cycles = 28'($urandom);
        retired_instructions = 13'($urandom);
        predictions_made = 13'($urandom);
        correct_predictions = 13'($urandom);
        invalid_clk_cycles = 13'($urandom);
    endtask

    // Called at a negedge; waits for the start bit, checks every cycle of the frame, returns at the done cycle
    task automatic rx_frame(input int cpb, output int t_low);
        int   n = 0;
        int   errs = 0;
        logic e;
        logic [7:0] b;
        while (tx_s !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_low", tx_s, 1'b0);
        t_low = n;
        for (int i = 0; i < 14; i++) begin
            b = 8'h00;
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < cpb; c++) begin
                    e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : exp_q[i][k - 1];
                    if (tx_s !== e || busy_s !== 1'b1 || done_s !== 1'b0) errs++;
                    if (k >= 1 && k <= 8 && c == cpb / 2) b[k - 1] = tx_s;
                    @(negedge clk);
                end
            end
            rx_q[i] = b;
            check($sformatf("byte%0d", i), b, exp_q[i]);
        end
        check("wave", errs, 0);
        check("fin_done", done_s, 1'b1);
        check("fin_busy", busy_s, 1'b0);
        check("fin_tx", tx_s, 1'b1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int errs;
        rst_n = 1'b0;
        start = 1'b0;
        set_golden();
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = i[0];
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 ||
                tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) errs++;
        end
        check("rst_hold", errs, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", tx1, 1'b1);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);

        build_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_frame(4, t);
        check("start_latency", t, 0);
        for (int i = 0; i < 14; i++) check($sformatf("golden%0d", i), rx_q[i], golden_b[i]);
        @(negedge clk);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clk_cycles = '1;
        retired_instructions = '1;
        predictions_made = '1;
        correct_predictions = '1;
        invalid_clk_cycles = '1;
        rx_frame(4, t);
        check("snap_b13", rx_q[13], 8'h5B);
        @(negedge clk);

        for (int r = 0; r < 4; r++) begin
            set_random();
            build_frame();
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            set_random();
            rx_frame(4, t);
            @(negedge clk);
        end

        set_random();
        build_frame();
        start = 1'b1;
        @(negedge clk);
        set_random();
        rx_frame(4, t);
        build_frame();
        rx_frame(4, t);
        check("b2b_gap", t, 2);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("no_retrigger", busy1, 1'b0);

        set_random();
        build_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (33 * 4) @(negedge clk);
        check("mid_bit", tx1, exp_q[3][2]);
        check("mid_busy", busy1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", tx1, 1'b1);
        check("abort_busy", busy1, 1'b0);
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (done1 !== 1'b0 || tx1 !== 1'b1) errs++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done1 !== 1'b0 || tx1 !== 1'b1 || busy1 !== 1'b0) errs++;
        end
        check("abort_quiet", errs, 0);
        set_random();
        build_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_frame(4, t);
        check("fresh_sync", rx_q[0], 8'hA5);
        @(negedge clk);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 1'b1;
        set_golden();
        build_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rx_frame(2, t);
        for (int i = 0; i < 14; i++) check($sformatf("cpb2_golden%0d", i), rx_q[i], golden_b[i]);
        @(negedge clk);
        check("cpb2_idle", busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
